// File: rtl/ucode_seq_pkg.sv
// rtl/ucode_seq_pkg.sv - shared constants and types for the ucode sequencer
// Purpose: holds the u_f18 branch-op encodings, the ROM address width and
//          idle address, and the sequencer state encoding.
// Ports:   none (package).
package ucode_pkg;

  localparam int UADDR_W = 9;
  localparam logic [UADDR_W-1:0] UIDLE_ADDR = 9'h000;

  // u_f18[11:9] branch ops
  localparam logic [2:0] OP_NEXT = 3'd0;
  localparam logic [2:0] OP_JMP  = 3'd1;
  localparam logic [2:0] OP_BZ   = 3'd2;
  localparam logic [2:0] OP_BNZ  = 3'd3;
  localparam logic [2:0] OP_BNEG = 3'd4;
  localparam logic [2:0] OP_BODD = 3'd5;
  localparam logic [2:0] OP_CALL = 3'd6;
  localparam logic [2:0] OP_RET  = 3'd7;

  typedef enum logic [0:0] {
    UST_IDLE = 1'b0,
    UST_RUN  = 1'b1
  } ucode_state_e;

  // Plain-vector aliases of the state enum for the state register.
  localparam logic [0:0] ST_IDLE = UST_IDLE;
  localparam logic [0:0] ST_RUN  = UST_RUN;

endpackage

// File: rtl/ucode_seq_if.sv
// rtl/ucode_seq_if.sv - IU/ucode-engine signal bundle for the sequencer
// Purpose: groups the IU request/condition inputs and sequencer outputs.
// Modports:
//   master - IU / ucode_reg side: drives start, entry, stall, kill, u_f18
//            and branch conditions; observes addresses and status.
//   slave  - sequencer side: the reverse.
interface ucode_seq_if;

  logic                           ucode_start;
  logic [ucode_pkg::UADDR_W-1:0]  ucode_entry;
  logic                           ie_stall_ucode;
  logic                           ie_kill_ucode;
  logic [11:0]                    u_f18;
  logic                           cond_zero;
  logic                           reg5_31;
  logic                           a_oprd_0_l;
  logic [ucode_pkg::UADDR_W-1:0]  nxt_ucode_cnt;
  logic [ucode_pkg::UADDR_W-1:0]  ucode_cnt;
  logic                           sel_fxx_default;
  logic                           ucode_busy;
  logic                           ucode_done;
  logic                           ucode_err;

  modport master (
    output ucode_start, ucode_entry, ie_stall_ucode, ie_kill_ucode,
           u_f18, cond_zero, reg5_31, a_oprd_0_l,
    input  nxt_ucode_cnt, ucode_cnt, sel_fxx_default,
           ucode_busy, ucode_done, ucode_err
  );

  modport slave (
    input  ucode_start, ucode_entry, ie_stall_ucode, ie_kill_ucode,
           u_f18, cond_zero, reg5_31, a_oprd_0_l,
    output nxt_ucode_cnt, ucode_cnt, sel_fxx_default,
           ucode_busy, ucode_done, ucode_err
  );

endinterface

// File: rtl/ucode_seq_rstack.sv
// rtl/ucode_seq_rstack.sv - two-entry micro-subroutine return stack
// Purpose: LIFO of return addresses for CALL/RET.
// Ports:
//   clk, reset_l   - clock, synchronous active-low reset (empties stack)
//   clr            - synchronous clear (kill / error / end)
//   push, push_data- push a return address (ignored when full)
//   pop            - discard top entry (ignored when empty)
//   top            - current top entry (undefined when empty)
//   full, empty    - occupancy flags
module ucode_rstack #(
  parameter int W     = 9,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset_l,
  input  logic         clr,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic [W-1:0] top,
  output logic         full,
  output logic         empty
);

  logic [W-1:0] mem [0:1];
  logic [1:0]   count;

  assign full  = (count == 2'(DEPTH));
  assign empty = (count == 2'd0);
  assign top   = (count == 2'd2) ? mem[1] : mem[0];

  always_ff @(posedge clk) begin
    if (!reset_l || clr) begin
      count <= 2'd0;
    end else if (push && !full) begin
      mem[count[0]] <= push_data;
      count         <= count + 2'd1;
    end else if (pop && !empty) begin
      count <= count - 2'd1;
    end
  end

endmodule

// File: rtl/ucode_seq.sv
// rtl/ucode_seq.sv - IU microcode sequencer (next ROM address generation)
// Purpose: computes nxt_ucode_cnt from the registered branch field u_f18,
//          the IU branch conditions, entry/stall/kill and the return stack;
//          drives sel_fxx_default whenever no valid micro-instruction runs.
// Ports:
//   clk, reset_l - clock, synchronous active-low reset
//   bus (slave)  - ucode_start/ucode_entry, ie_stall_ucode, ie_kill_ucode,
//                  u_f18, cond_zero, reg5_31, a_oprd_0_l in;
//                  nxt_ucode_cnt, sel_fxx_default (combinational),
//                  ucode_cnt, ucode_busy, ucode_done, ucode_err (registered) out
module ucode_seq
  import ucode_pkg::*;
#(
  parameter int ADDR_W     = UADDR_W,
  parameter int RSTK_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_l,
  ucode_seq_if.slave  bus
);

  logic [0:0]        state, state_nxt;
  logic [2:0]        op;
  logic [ADDR_W-1:0] target, cnt_inc, stk_top, nxt;
  logic              at_max, take, sel;
  logic              push, pop, clr;
  logic              stk_full, stk_empty;
  logic              fault, fin;
  logic              done_nxt, err_nxt;

  assign op      = bus.u_f18[11:9];
  assign target  = bus.u_f18[ADDR_W-1:0];
  assign cnt_inc = bus.ucode_cnt + 1'b1;
  // Any +1 from the top address would wrap to the NOP word: illegal.
  assign at_max  = &bus.ucode_cnt;

  ucode_rstack #(
    .W     (ADDR_W),
    .DEPTH (RSTK_DEPTH)
  ) u_rstack (
    .clk       (clk),
    .reset_l   (reset_l),
    .clr       (clr),
    .push      (push),
    .push_data (cnt_inc),
    .pop       (pop),
    .top       (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_comb begin
    nxt       = UIDLE_ADDR;
    sel       = 1'b1;
    state_nxt = state;
    push      = 1'b0;
    pop       = 1'b0;
    clr       = 1'b0;
    take      = 1'b0;
    fault     = 1'b0;
    fin       = 1'b0;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    if (state == ST_IDLE) begin
      if (bus.ucode_start && !bus.ie_stall_ucode && !bus.ie_kill_ucode) begin
        nxt       = bus.ucode_entry;
        sel       = 1'b0;
        state_nxt = ST_RUN;
      end
    end else if (bus.ie_kill_ucode) begin
      clr       = 1'b1;
      state_nxt = ST_IDLE;
    end else if (bus.ie_stall_ucode) begin
      // Hold the micro-PC; stack untouched until unstalled.
      nxt = bus.ucode_cnt;
      sel = 1'b0;
    end else begin
      sel = 1'b0;
      case (op)
        OP_JMP:  take = 1'b1;
        OP_BZ:   take = bus.cond_zero;
        OP_BNZ:  take = !bus.cond_zero;
        OP_BNEG: take = bus.reg5_31;
        OP_BODD: take = !bus.a_oprd_0_l;
        default: take = 1'b0;
      endcase

      if (op == OP_CALL) begin
        // A return address past the top of ROM would also wrap.
        if (stk_full || at_max) begin
          fault = 1'b1;
        end else begin
          push = 1'b1;
          nxt  = target;
        end
      end else if (op == OP_RET) begin
        if (!stk_empty) begin
          pop = 1'b1;
          nxt = stk_top;
        end else begin
          fin = 1'b1;
        end
      end else if (take) begin
        nxt = target;
      end else if (at_max) begin
        fault = 1'b1;
      end else begin
        nxt = cnt_inc;
      end

      if (fault || fin) begin
        nxt       = UIDLE_ADDR;
        sel       = 1'b1;
        state_nxt = ST_IDLE;
        clr       = 1'b1;
        err_nxt   = fault;
        done_nxt  = fin;
      end
    end
  end

  assign bus.nxt_ucode_cnt   = nxt;
  assign bus.sel_fxx_default = sel;

  always_ff @(posedge clk) begin
    if (!reset_l) begin
      state          <= ST_IDLE;
      bus.ucode_cnt  <= UIDLE_ADDR;
      bus.ucode_busy <= 1'b0;
      bus.ucode_done <= 1'b0;
      bus.ucode_err  <= 1'b0;
    end else begin
      state          <= state_nxt;
      bus.ucode_cnt  <= nxt;
      bus.ucode_busy <= (state_nxt == ST_RUN);
      bus.ucode_done <= done_nxt;
      bus.ucode_err  <= err_nxt;
    end
  end

endmodule
